demo: RTL and testbench

- Free-running up-counter with a power-on lock-wait stage, used as the reference bring-up block of the FPGA design template.
- After reset release, an internal lock timer models a clocking resource that must lock before the datapath runs.
- Once locked, an 8-bit output counter advances on every clock edge while `enable` is high.
- Everything is synchronous to one clock; `out` feeds LEDs or debug logic at top level.

---
 rtl/demo_pkg.sv | 14 +
 rtl/demo_lock_timer.sv | 54 +++++
 rtl/demo.sv | 42 ++++
 tb/tb_demo.sv | 130 +++++++++++++
 4 files changed

// File: rtl/demo_pkg.sv
// Shared types and default constants for the demo bring-up counter.
// The state enum is kept to one bit so the lock FSM stays a single flop.
package demo_pkg;

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } demo_state_e;

    localparam int DEMO_WIDTH       = 8;
    localparam int DEMO_LOCK_CYCLES = 16;
    localparam int DEMO_STEP        = 1;

endpackage

// File: rtl/demo_lock_timer.sv
// Power-on lock timer: models a clocking resource that needs LOCK_CYCLES
// edges after reset release before the datapath may run.
module demo_lock_timer
    import demo_pkg::*;
#(
    parameter int LOCK_CYCLES = DEMO_LOCK_CYCLES
) (
    input  logic clk,
    input  logic reset,
    output logic locked
);

    localparam int            CW   = $clog2(LOCK_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(LOCK_CYCLES - 1);

    demo_state_e   state;
    demo_state_e   state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The counter freezes on the edge that enters RUN; RUN only exits via reset.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            WAIT_LOCK: begin
                if (cnt == LAST) begin
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = WAIT_LOCK;
            end
        endcase
    end

    assign locked = (state == RUN);

endmodule

// File: rtl/demo.sv
// Reference bring-up block: a free-running up-counter that only starts
// once the lock timer reports lock. `out` is driven straight from a flop.
module demo
    import demo_pkg::*;
#(
    parameter int WIDTH       = DEMO_WIDTH,
    parameter int LOCK_CYCLES = DEMO_LOCK_CYCLES,
    parameter int STEP        = DEMO_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] out
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // Modulo-2^WIDTH add: the counter wraps naturally, no saturation.
    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        return a + b;
    endfunction

    logic locked;

    demo_lock_timer #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lock (
        .clk   (clk),
        .reset (reset),
        .locked(locked)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out <= '0;
        end else if (locked && enable) begin
            out <= wrap_add(out, STEP_W);
        end
    end

endmodule

// File: tb/tb_demo.sv
// Directed self-checking bench for demo: reset, lock wait, counting,
// hold/resume, wrap and reset during RUN.
module tb_demo;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] out;

    int total  = 0;
    int passed = 0;

    demo dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .out   (out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        total++;
        assert (out === exp) passed++;
        else $error("FAIL %s: out=%0d expected=%0d", tag, out, exp);
    endtask

    // Hold reset for one edge, then release just after that edge.
    task automatic restart(input logic en);
        reset  = 1'b0;
        enable = en;
        tick();
        chk("restart_zero", 8'd0);
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b1;

        // Reset hold with enable high
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_hold", 8'd0);
        end

        // Lock wait: edges 1..16 stay at 0, edge 17 -> 1, edge 26 -> 10
        reset = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            tick();
            if (e <= 16) chk("lock_wait", 8'd0);
            else if (e == 17) chk("first_inc", 8'd1);
            else if (e == 26) chk("edge26", 8'd10);
        end

        // Normal count: enable low through the lock wait, then 200 enabled edges
        restart(1'b0);
        for (int e = 0; e < 16; e++) tick();
        chk("locked_idle", 8'd0);
        enable = 1'b1;
        for (int e = 0; e < 200; e++) tick();
        chk("count200", 8'd200);
        enable = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick();
            chk("count200_hold", 8'd200);
        end

        // Hold and resume: 10 on, 7 off, 5 on
        restart(1'b0);
        for (int e = 0; e < 16; e++) tick();
        enable = 1'b1;
        for (int e = 0; e < 10; e++) tick();
        chk("hold_pre", 8'd10);
        enable = 1'b0;
        for (int e = 0; e < 7; e++) begin
            tick();
            chk("hold_gap", 8'd10);
        end
        enable = 1'b1;
        for (int e = 0; e < 5; e++) tick();
        chk("resume", 8'd15);

        // Enable toggling every cycle advances once per high sample
        for (int e = 0; e < 8; e++) begin
            enable = e[0];
            tick();
        end
        chk("toggle", 8'd19);

        // Wrap: 260 enabled edges from 0
        restart(1'b0);
        for (int e = 0; e < 16; e++) tick();
        enable = 1'b1;
        for (int e = 1; e <= 260; e++) begin
            tick();
            if (e == 255) chk("wrap_255", 8'd255);
            else if (e == 256) chk("wrap_0", 8'd0);
            else if (e == 260) chk("wrap_end", 8'd4);
        end

        // Reset mid-run at out=77
        restart(1'b0);
        for (int e = 0; e < 16; e++) tick();
        enable = 1'b1;
        for (int e = 0; e < 77; e++) tick();
        chk("pre_reset_77", 8'd77);
        #3;
        reset = 1'b0;
        #1;
        chk("async_reset", 8'd0);
        tick();
        chk("reset_low", 8'd0);
        reset = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (e <= 16) chk("relock_wait", 8'd0);
            else chk("relock_count", 8'(e - 16));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
